// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode encodings and FSM states shared by the sequential ALU.
package alu_seq_pkg;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;
  typedef enum logic {IDLE, EXEC} state_e;
endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add multiplier, one bit of a per cycle LSB-first.
// done_o is high during the final step; prod_o is the accumulator including that step.
module alu_seq_mul #(
  parameter int WIDTH   = 8,
  parameter int A_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 flush_i,
  input  logic [A_WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   prod_o
);
  localparam int CW = $clog2(A_WIDTH + 1);
  logic               run_q, run_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [A_WIDTH-1:0] a_q, a_d;
  logic [2*WIDTH-1:0] b_q, b_d, acc_q, acc_d, sum;
  assign sum    = acc_q + (a_q[0] ? b_q : '0);
  assign done_o = run_q && (cnt_q == CW'(A_WIDTH - 1));
  assign prod_o = sum;
  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (start_i) begin
      run_d = 1'b1;
      cnt_d = '0;
      a_d   = a_i;
      b_d   = {{WIDTH{1'b0}}, b_i};
      acc_d = '0;
    end else if (run_q) begin
      run_d = !flush_i && !done_o;
      cnt_d = cnt_q + 1'b1;
      a_d   = a_q >> 1;
      b_d   = b_q << 1;
      acc_d = sum;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with in/out handshake; single-cycle ops inline.
// Define ALU_SEQ_MUL_EN for the multi-cycle multiplier; otherwise opcode 111 passes b through.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int A_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  input  logic [2:0]         opcode,
  input  logic [A_WIDTH-1:0] a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  output logic [WIDTH-1:0]   data_out,
  output logic               zflag,
  output logic               c
);
  logic [WIDTH-1:0] ext_a, res, data_q, data_d;
  logic             cr, z_q, z_d, c_q, c_d, valid_q, valid_d;
  assign ext_a     = WIDTH'(a);
  assign data_out  = data_q;
  assign zflag     = z_q;
  assign c         = c_q;
  assign out_valid = valid_q;
  always_comb begin
    res = b;
    cr  = 1'b0;
    case (opcode)
      OP_ADD: {cr, res} = {1'b0, b} + {1'b0, ext_a};
      OP_SUB: begin
        res = b - ext_a;
        cr  = b >= ext_a;
      end
      OP_AND: res = b & ext_a;
      OP_OR:  res = b | ext_a;
      OP_XOR: res = b ^ ext_a;
      OP_SHL: begin
        res = b << 1;
        cr  = b[WIDTH-1];
      end
      OP_SHR: begin
        res = b >> 1;
        cr  = b[0];
      end
      default: res = b;
    endcase
  end
`ifdef ALU_SEQ_MUL_EN
  state_e             state_q, state_d;
  logic               mul_done;
  logic [2*WIDTH-1:0] prod;
  assign in_ready = state_q == IDLE;
  alu_seq_mul #(.WIDTH(WIDTH), .A_WIDTH(A_WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start_i (in_valid && in_ready && opcode == OP_MUL),
    .flush_i (flush),
    .a_i     (a),
    .b_i     (b),
    .done_o  (mul_done),
    .prod_o  (prod)
  );
  // flush beats a completing MUL so a cancelled product never reaches the flags
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    z_d     = z_q;
    c_d     = c_q;
    valid_d = 1'b0;
    if (state_q == EXEC) begin
      if (flush) begin
        state_d = IDLE;
      end else if (mul_done) begin
        state_d = IDLE;
        data_d  = prod[WIDTH-1:0];
        z_d     = prod[WIDTH-1:0] == '0;
        c_d     = |prod[2*WIDTH-1:WIDTH];
        valid_d = 1'b1;
      end
    end else if (in_valid) begin
      if (opcode == OP_MUL) begin
        state_d = EXEC;
      end else begin
        data_d  = res;
        z_d     = res == '0;
        c_d     = cr;
        valid_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign in_ready     = 1'b1;
  always_comb begin
    data_d  = data_q;
    z_d     = z_q;
    c_d     = c_q;
    valid_d = 1'b0;
    if (in_valid) begin
      data_d  = res;
      z_d     = res == '0;
      c_d     = cr;
      valid_d = 1'b1;
    end
  end
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      z_q     <= z_d;
      c_q     <= c_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table plus hand-written MUL/flush/reset sequences for alu_seq.
module tb_alu_seq;
  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, flush, out_valid, zflag, c;
  logic [2:0] opcode;
  logic [4:0] a;
  logic [7:0] b, data_out;
  int         n_vec = 0;
  int         n_err = 0;
  typedef struct {
    logic [2:0] op;
    logic [4:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       z;
    logic       cf;
  } vec_t;
  vec_t vq[$];
  always #5 clk = ~clk;
  alu_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .data_out  (data_out),
    .zflag     (zflag),
    .c         (c)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_out(input string nm, input logic [7:0] d, input logic z, input logic cf);
    chk({nm, " data"}, 32'(data_out), 32'(d));
    chk({nm, " z"}, 32'(zflag), 32'(z));
    chk({nm, " c"}, 32'(c), 32'(cf));
  endtask
  task automatic drive(input logic [2:0] op, input logic [4:0] av, input logic [7:0] bv);
    in_valid = 1'b1;
    opcode   = op;
    a        = av;
    b        = bv;
  endtask
  initial begin
    int lat, low, seen;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; opcode = '0; a = '0; b = '0;
    vq.push_back('{3'b000, 5'd1,  8'h01, 8'h02, 1'b0, 1'b0});
    vq.push_back('{3'b000, 5'd0,  8'h00, 8'h00, 1'b1, 1'b0});
    vq.push_back('{3'b000, 5'd31, 8'hF0, 8'h0F, 1'b0, 1'b1});
    vq.push_back('{3'b000, 5'd1,  8'hFF, 8'h00, 1'b1, 1'b1});
    vq.push_back('{3'b001, 5'd5,  8'h05, 8'h00, 1'b1, 1'b1});
    vq.push_back('{3'b001, 5'd6,  8'h05, 8'hFF, 1'b0, 1'b0});
    vq.push_back('{3'b001, 5'd0,  8'h00, 8'h00, 1'b1, 1'b1});
    vq.push_back('{3'b010, 5'h0F, 8'hF3, 8'h03, 1'b0, 1'b0});
    vq.push_back('{3'b010, 5'h0C, 8'hF3, 8'h00, 1'b1, 1'b0});
    vq.push_back('{3'b011, 5'h10, 8'h01, 8'h11, 1'b0, 1'b0});
    vq.push_back('{3'b100, 5'h1F, 8'h1F, 8'h00, 1'b1, 1'b0});
    vq.push_back('{3'b100, 5'h1F, 8'hFF, 8'hE0, 1'b0, 1'b0});
    vq.push_back('{3'b101, 5'd0,  8'h81, 8'h02, 1'b0, 1'b1});
    vq.push_back('{3'b101, 5'd0,  8'h40, 8'h80, 1'b0, 1'b0});
    vq.push_back('{3'b110, 5'd0,  8'h01, 8'h00, 1'b1, 1'b1});
    vq.push_back('{3'b110, 5'd0,  8'h80, 8'h40, 1'b0, 1'b0});
`ifndef ALU_SEQ_MUL_EN
    vq.push_back('{3'b111, 5'd31, 8'h09, 8'h09, 1'b0, 1'b0});
    vq.push_back('{3'b111, 5'd7,  8'h00, 8'h00, 1'b1, 1'b0});
`endif
    repeat (2) @(negedge clk);
    chk_out("reset", 8'h00, 1'b0, 1'b0);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset in_ready", 32'(in_ready), 1);
    rst = 1'b0;
    @(negedge clk);
    foreach (vq[i]) begin
      drive(vq[i].op, vq[i].a, vq[i].b);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 1);
      chk_out($sformatf("vec%0d", i), vq[i].d, vq[i].z, vq[i].cf);
      @(negedge clk);
      chk($sformatf("vec%0d pulse end", i), 32'(out_valid), 0);
      chk($sformatf("vec%0d hold", i), 32'(data_out), 32'(vq[i].d));
    end
    drive(3'b000, 5'd1, 8'h01);
    @(negedge clk);
    chk("b2b add valid", 32'(out_valid), 1);
    chk_out("b2b add", 8'h02, 1'b0, 1'b0);
    drive(3'b101, 5'd0, 8'h81);
    @(negedge clk);
    chk("b2b shl valid", 32'(out_valid), 1);
    chk_out("b2b shl", 8'h02, 1'b0, 1'b1);
    drive(3'b110, 5'd0, 8'h01);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b shr valid", 32'(out_valid), 1);
    chk_out("b2b shr", 8'h00, 1'b1, 1'b1);
    @(negedge clk);
    chk("b2b end", 32'(out_valid), 0);
    drive(3'b000, 5'd3, 8'h04);
    flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("idle flush valid", 32'(out_valid), 1);
    chk_out("idle flush", 8'h07, 1'b0, 1'b0);
`ifdef ALU_SEQ_MUL_EN
    drive(3'b111, 5'd31, 8'h09);
    lat = 0; low = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (!in_ready) low++;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk("mul latency", 32'(lat), 6);
    chk("mul ready low cycles", 32'(low), 5);
    chk_out("mul", 8'h17, 1'b0, 1'b1);
    @(negedge clk);
    chk("mul pulse end", 32'(out_valid), 0);
    drive(3'b111, 5'd31, 8'h09);
    @(negedge clk);
    in_valid = 1'b0;
    chk("flush busy", 32'(in_ready), 0);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush ready", 32'(in_ready), 1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    chk("flush no valid", 32'(seen), 0);
    chk_out("flush hold", 8'h17, 1'b0, 1'b1);
`endif
    drive(3'b111, 5'd31, 8'h09);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk_out("async rst", 8'h00, 1'b0, 1'b0);
    chk("async rst valid", 32'(out_valid), 0);
    chk("async rst ready", 32'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("post rst no valid", 32'(seen), 0);
    drive(3'b000, 5'd2, 8'h03);
    @(negedge clk);
    in_valid = 1'b0;
    chk("post rst add valid", 32'(out_valid), 1);
    chk_out("post rst add", 8'h05, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
